// File: rtl/dram_ctrl.sv
// Data-memory controller: turns one cache-side byte/half/word/double access into a
// single aligned 64-bit req/ack bus transaction and returns extended read data.
module dram_ctrl #(
  parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0100_0000,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic [63:0] din,
  output logic [63:0] dout,
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  wr_ctrl,
  output logic [1:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int            CW      = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_READY = 2'b00,
    S_RD    = 2'b01,
    S_WR    = 2'b10,
    S_ERR   = 2'b11
  } state_t;

  state_t        r_state;
  logic [2:0]    r_off, r_rd_ctrl;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_dout, r_mem_addr, r_mem_wdata;
  logic [7:0]    r_mem_wstrb;
  logic          r_mem_req, r_mem_we;

  logic          w_rd, w_wr, w_err;
  logic [3:0]    w_size;
  logic [7:0]    w_mask;
  logic [64:0]   w_end, w_lim;
  logic [63:0]   w_lane, w_ext;

  // Request decode; range math is 65 bits wide so addr+size cannot wrap.
  always_comb begin
    w_rd   = |rd_ctrl;
    w_wr   = |wr_ctrl;
    w_size = 4'd1;
    w_mask = 8'h01;
    if (w_wr) begin
      case (wr_ctrl)
        3'd2:    w_size = 4'd2;
        3'd3:    w_size = 4'd4;
        3'd4:    w_size = 4'd8;
        default: w_size = 4'd1;
      endcase
    end else begin
      case (rd_ctrl)
        3'd3, 3'd4: w_size = 4'd2;
        3'd5, 3'd7: w_size = 4'd4;
        3'd6:       w_size = 4'd8;
        default:    w_size = 4'd1;
      endcase
    end
    case (w_size)
      4'd2:    w_mask = 8'h03;
      4'd4:    w_mask = 8'h0F;
      4'd8:    w_mask = 8'hFF;
      default: w_mask = 8'h01;
    endcase
    w_end = {1'b0, addr} + {61'd0, w_size};
    w_lim = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    w_err = (w_rd && w_wr) || (wr_ctrl > 3'd4) ||
            ((addr[2:0] & (w_size[2:0] - 3'd1)) != 3'd0) ||
            (addr < MEM_BASE) || (w_end > w_lim);
  end

  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    case (r_rd_ctrl)
      3'd1:    w_ext = {{56{w_lane[7]}}, w_lane[7:0]};
      3'd2:    w_ext = {56'd0, w_lane[7:0]};
      3'd3:    w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'd4:    w_ext = {48'd0, w_lane[15:0]};
      3'd5:    w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'd7:    w_ext = {32'd0, w_lane[31:0]};
      default: w_ext = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_READY;
      r_off       <= 3'd0;
      r_rd_ctrl   <= 3'd0;
      r_cnt       <= '0;
      r_dout      <= 64'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_mem_wstrb <= 8'd0;
    end else begin
      case (r_state)
        S_READY: begin
          if (w_rd || w_wr) begin
            if (w_err) begin
              r_state <= S_ERR;
            end else begin
              r_off      <= addr[2:0];
              r_rd_ctrl  <= rd_ctrl;
              r_mem_addr <= {addr[63:3], 3'b000};
              r_mem_req  <= 1'b1;
              r_cnt      <= '0;
              if (w_wr) begin
                r_mem_we    <= 1'b1;
                r_mem_wstrb <= w_mask << addr[2:0];
                r_mem_wdata <= din << {addr[2:0], 3'b000};
                r_state     <= S_WR;
              end else begin
                r_mem_we    <= 1'b0;
                r_mem_wstrb <= 8'd0;
                r_state     <= S_RD;
              end
            end
          end
        end
        S_RD, S_WR: begin
          // Ack wins over timeout when both land on the same edge.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_READY;
            if (r_state == S_RD) r_dout <= w_ext;
          end else if (r_cnt == TO_LAST) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_ERR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_READY;
      endcase
    end
  end

  assign state     = r_state;
  assign dout      = r_dout;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_dram_ctrl.sv
// Randomized bench for dram_ctrl: a transaction-level model predicts every cycle's
// outputs, a negedge process compares them, and directed cases pin literal values.
module tb_dram_ctrl;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SIZE = 64'h0000_0000_0100_0000;
  localparam int          TO   = 16;

  logic        clk = 1'b0, rst;
  logic [63:0] addr, din, dout, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  rd_ctrl, wr_ctrl;
  logic [1:0]  state;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_wstrb;

  dram_ctrl #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
    .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl), .state(state),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit          check_en = 1'b0;
  logic [1:0]  exp_state = 2'b00;
  logic        exp_req = 1'b0, exp_we = 1'b0;
  logic [63:0] exp_dout = 64'd0, exp_addr = 64'd0, exp_wdata = 64'd0;
  logic [7:0]  exp_wstrb = 8'd0;
  logic [1:0]  cap_state;
  logic        cap_req;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_wstrb;
  int          cap_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic int sz_of(input logic [2:0] rd, input logic [2:0] wr);
    int rsz[8] = '{0, 1, 1, 2, 2, 4, 8, 4};
    if (wr != 3'd0) return 1 << (int'(wr) - 1);
    return rsz[rd];
  endfunction

  function automatic bit legal(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] a);
    int sz;
    logic [64:0] e, lim;
    if (rd != 3'd0 && wr != 3'd0) return 1'b0;
    if (wr > 3'd4) return 1'b0;
    sz = sz_of(rd, wr);
    if ((a % 64'(sz)) != 64'd0) return 1'b0;
    e   = {1'b0, a} + 65'(sz);
    lim = {1'b0, BASE} + {1'b0, SIZE};
    if (a < BASE || e > lim) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] rdata, input int off, input logic [2:0] rd);
    int n;
    logic [63:0] lane, mask, v;
    n    = sz_of(rd, 3'd0) * 8;
    lane = rdata >> (off * 8);
    if (n == 64) return lane;
    mask = (64'd1 << n) - 64'd1;
    v    = lane & mask;
    if ((rd == 3'd1 || rd == 3'd3 || rd == 3'd5) && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("state", 64'(state), 64'(exp_state));
      chk("dout", dout, exp_dout);
      chk("mem_req", 64'(mem_req), 64'(exp_req));
      if (exp_req) begin
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_wstrb));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rd_ctrl = 3'd0; wr_ctrl = 3'd0;
      addr = {$urandom, $urandom};
      mem_ack = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
  endtask

  // Drive one request; ackdly = busy cycles before the ack cycle (>= TO means never).
  task automatic issue(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] a,
                       input logic [63:0] d, input int ackdly, input logic [63:0] rdata);
    bit ok;
    int sz, off;
    ok  = legal(rd, wr, a);
    off = int'(a[2:0]);
    sz  = ok ? sz_of(rd, wr) : 1;
    rd_ctrl = rd; wr_ctrl = wr; addr = a; din = d; mem_ack = 1'b0;
    @(posedge clk); #1;
    rd_ctrl = 3'd0; wr_ctrl = 3'd0;
    addr = {$urandom, $urandom}; din = {$urandom, $urandom};
    cap_state = state; cap_req = mem_req; cap_addr = mem_addr;
    cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; cap_busy = 0;
    if (!ok) begin
      exp_state = 2'b11; exp_req = 1'b0;
      @(posedge clk); #1;
      exp_state = 2'b00;
      return;
    end
    exp_state = (wr != 3'd0) ? 2'b10 : 2'b01;
    exp_req   = 1'b1;
    exp_we    = (wr != 3'd0);
    exp_addr  = {a[63:3], 3'b000};
    if (wr != 3'd0) begin
      exp_wdata = d << (off * 8);
      exp_wstrb = 8'(((1 << sz) - 1) << off);
    end else begin
      exp_wstrb = 8'd0;
    end
    for (int c = 0; c < TO; c++) begin
      if (state == 2'b01 || state == 2'b10) cap_busy++;
      mem_ack   = (c == ackdly);
      mem_rdata = (c == ackdly) ? rdata : {$urandom, $urandom};
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (c == ackdly) begin
        exp_req = 1'b0; exp_state = 2'b00;
        if (rd != 3'd0) exp_dout = ext(rdata, off, rd);
        return;
      end
    end
    exp_req = 1'b0; exp_state = 2'b11;
    @(posedge clk); #1;
    exp_state = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; addr = 64'd0; din = 64'd0; rd_ctrl = 3'd0; wr_ctrl = 3'd0;
    mem_rdata = 64'd0; mem_ack = 1'b0;
    #3;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check_en = 1'b1;
    idle(2);

    issue(3'd0, 3'd4, 64'h8000_0010, 64'h1122_3344_5566_7788, 1, 64'd0);
    chk("sd_addr", cap_addr, 64'h8000_0010);
    chk("sd_wdata", cap_wdata, 64'h1122_3344_5566_7788);
    chk("sd_wstrb", 64'(cap_wstrb), 64'hFF);
    chk("sd_busy", 64'(cap_busy), 64'd2);
    issue(3'd0, 3'd1, 64'h8000_0013, 64'h0000_0000_0000_00AB, 0, 64'd0);
    chk("sb_addr", cap_addr, 64'h8000_0010);
    chk("sb_wstrb", 64'(cap_wstrb), 64'h08);
    chk("sb_lane", {56'd0, cap_wdata[31:24]}, 64'hAB);
    issue(3'd1, 3'd0, 64'h8000_0013, 64'd0, 2, 64'h0000_0000_AB00_0000);
    chk("lb", dout, 64'hFFFF_FFFF_FFFF_FFAB);
    issue(3'd2, 3'd0, 64'h8000_0013, 64'd0, 0, 64'h0000_0000_AB00_0000);
    chk("lbu", dout, 64'h0000_0000_0000_00AB);
    issue(3'd5, 3'd0, 64'h8000_0004, 64'd0, 0, 64'h8000_0001_0000_0000);
    chk("lw", dout, 64'hFFFF_FFFF_8000_0001);
    issue(3'd7, 3'd0, 64'h8000_0004, 64'd0, 0, 64'h8000_0001_0000_0000);
    chk("lwu", dout, 64'h0000_0000_8000_0001);

    issue(3'd3, 3'd0, 64'h8000_0007, 64'd0, 0, 64'd0);
    chk("mis_state", 64'(cap_state), 64'd3);
    chk("mis_req", 64'(cap_req), 64'd0);
    issue(3'd6, 3'd0, 64'h7FFF_FFF8, 64'd0, 0, 64'd0);
    chk("oor_state", 64'(cap_state), 64'd3);
    issue(3'd6, 3'd4, 64'h8000_0000, 64'd0, 0, 64'd0);
    chk("both_state", 64'(cap_state), 64'd3);
    chk("both_req", 64'(cap_req), 64'd0);
    chk("err_dout", dout, 64'h0000_0000_8000_0001);

    issue(3'd6, 3'd0, BASE + 64'h100, 64'd0, TO + 5, 64'd0);
    chk("to_busy", 64'(cap_busy), 64'(TO));
    chk("to_dout", dout, 64'h0000_0000_8000_0001);
    issue(3'd6, 3'd0, BASE + 64'h108, 64'd0, 0, 64'hDEAD_BEEF_CAFE_F00D);
    chk("fast_busy", 64'(cap_busy), 64'd1);
    chk("fast_dout", dout, 64'hDEAD_BEEF_CAFE_F00D);
    issue(3'd6, 3'd0, BASE, 64'd0, TO - 1, 64'h0123_4567_89AB_CDEF);
    chk("lastack_busy", 64'(cap_busy), 64'(TO));
    chk("lastack_dout", dout, 64'h0123_4567_89AB_CDEF);

    issue(3'd6, 3'd0, BASE + SIZE - 64'd8, 64'd0, 0, 64'h55);
    chk("top_ld", 64'(cap_state), 64'd1);
    issue(3'd6, 3'd0, BASE + SIZE, 64'd0, 0, 64'd0);
    chk("past_top", 64'(cap_state), 64'd3);
    issue(3'd0, 3'd3, BASE + SIZE - 64'd4, 64'h1234_5678, 0, 64'd0);
    chk("top_sw", 64'(cap_state), 64'd2);
    issue(3'd0, 3'd4, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, 64'd0);
    chk("wrap", 64'(cap_state), 64'd3);
    issue(3'd0, 3'd5, BASE, 64'd0, 0, 64'd0);
    chk("bad_wr", 64'(cap_state), 64'd3);

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  rd, wr;
      logic [63:0] a;
      int k, dly;
      k = int'($urandom % 10); rd = 3'd0; wr = 3'd0;
      if (k < 5)      rd = 3'($urandom_range(1, 7));
      else if (k < 9) wr = 3'($urandom_range(1, 4));
      else begin rd = 3'($urandom); wr = 3'($urandom); end
      case ($urandom % 8)
        0:       a = BASE - 64'($urandom_range(1, 16));
        1:       a = BASE + SIZE - 64'($urandom_range(0, 16));
        default: a = BASE + 64'($urandom % 32'h0100_0000);
      endcase
      dly = ($urandom % 12 == 0) ? TO + 3 : int'($urandom_range(0, 4));
      if (rd == 3'd0 && wr == 3'd0) idle(1);
      else issue(rd, wr, a, {$urandom, $urandom}, dly, {$urandom, $urandom});
      if ($urandom % 3 == 0) idle(int'($urandom_range(1, 3)));
    end

    // Asynchronous reset in the middle of a read, then a stale ack.
    rd_ctrl = 3'd6; addr = BASE + 64'h40; mem_ack = 1'b0;
    @(posedge clk); #1;
    rd_ctrl = 3'd0;
    check_en = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(state), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_dout", dout, 64'd0);
    exp_state = 2'b00; exp_req = 1'b0; exp_dout = 64'd0;
    #2 rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    check_en = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_state", 64'(state), 64'd0);
    chk("late_ack_dout", dout, 64'd0);
    issue(3'd4, 3'd0, BASE + 64'h42, 64'd0, 1, 64'h0000_0000_9876_0000);
    chk("post_rst_lhu", dout, 64'h0000_0000_0000_9876);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Data-memory controller directly downstream of the data cache.
- Accepts single-beat byte/half/word/double read and write requests on the cache-facing port and converts them into one aligned 64-bit transaction on a req/ack memory bus.
- Returns read data aligned and sign- or zero-extended.
- Reports progress on a 2-bit state bus, which the cache polls for 2'b00 (ready).

Parameters:
- MEM_BASE, 64'h0000_0000_8000_0000, first byte address served.
- MEM_SIZE, 64'h0000_0000_0100_0000, bytes served starting at MEM_BASE.
- TIMEOUT, 64, max cycles mem_req may wait for mem_ack before abort.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- addr  in  64  byte address from cache
- din  in  64  write data, right-aligned (bits [n-1:0] hold the n-bit store value)
- dout  out  64  read result, extended; held until next completed read
- rd_ctrl  in  3  001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 ld, 111 lwu, 000 none
- wr_ctrl  in  3  001 sb, 010 sh, 011 sw, 100 sd, 000 none; 101-111 illegal
- state  out  2  00 READY, 01 RD_BUSY, 10 WR_BUSY, 11 ERROR
- mem_req  out  1  memory request valid
- mem_we  out  1  1 write, 0 read
- mem_addr  out  64  8-byte-aligned address ({addr[63:3],3'b000})
- mem_wdata  out  64  write data, lane-shifted by addr[2:0]*8
- mem_wstrb  out  8  byte enables, 0 for reads
- mem_rdata  in  64  read data, valid when mem_ack=1
- mem_ack  in  1  transaction complete, one-cycle pulse

Behaviour:
- Reset (rst=0, async): state=00, dout=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, timeout counter=0. Reset mid-transaction abandons it and does not wait for ack. A late ack arriving after reset is ignored.
- FSM states: READY, RD_BUSY, WR_BUSY, ERROR. The state output equals the encoding.
- READY, on each rising edge:
  - Both ctrls 0: stay.
  - Rejected to ERROR (no mem_req, dout unchanged): both ctrls nonzero; wr_ctrl in 101-111; misaligned; out of range.
  - Misaligned means addr[2:0] mod size != 0 (size 1/2/4/8 bytes). This also prevents crossing an 8-byte boundary.
  - Out of range means addr < MEM_BASE or addr+size > MEM_BASE+MEM_SIZE. Compute in 65 bits so no wrap-around.
  - Legal read: latch addr[2:0] and rd_ctrl, drive mem_addr, mem_we=0, mem_wstrb=0, mem_req=1, go to RD_BUSY.
  - Legal write: mem_we=1, mem_wstrb=((1<<size)-1)<<addr[2:0], mem_wdata=din<<(addr[2:0]*8), mem_req=1, go to WR_BUSY.
- RD_BUSY / WR_BUSY:
  - mem_req and all mem_* outputs are held stable until an edge samples mem_ack=1.
  - On that edge: mem_req=0, timeout counter clears, go to READY.
  - Read completion: dout updates on the same edge. Extract the lane at offset*8, then sign-extend (lb, lh, lw) or zero-extend (lbu, lhu, lwu); ld passes through.
  - Timeout: the counter increments on every busy edge without ack. On reaching TIMEOUT-1 without ack: mem_req=0, go to ERROR, dout unchanged.
- ERROR: lasts exactly one cycle, then READY unconditionally.
- Latency: the request edge is followed by at least one busy cycle. If mem_ack is high in the first cycle mem_req is high, state is 01/10 for exactly one cycle.
- Back-to-back operation: a request is accepted on every READY edge with nonzero ctrl, including the edge immediately after completion. The requester must change or clear ctrl in the cycle state returns to 00 to avoid a re-issue.
- mem_ack while mem_req=0 is ignored.
- addr, din and ctrl changes during busy are ignored; the latched values are used.

Test Plan:
- Reset with rst=0 mid-RD_BUSY -> state=00, mem_req=0 asynchronously; dout=0.
- sd addr=0x8000_0010 din=0x1122334455667788, ack after 2 cycles -> mem_wstrb=0xFF, mem_wdata=din, mem_addr=0x8000_0010; state 10 for 2 cycles, then 00.
- sb addr=0x8000_0013 din=0xAB -> mem_addr=0x8000_0010, mem_wstrb=0x08, mem_wdata[31:24]=0xAB. Then lb same addr with mem_rdata=0x00000000AB000000 -> dout=0xFFFF_FFFF_FFFF_FFAB; lbu -> 0xAB.
- lw addr=0x8000_0004, mem_rdata=0x8000_0001_0000_0000 -> dout=0xFFFF_FFFF_8000_0001; lwu -> 0x0000_0000_8000_0001.
- lh addr=0x8000_0007 (misaligned), ld addr=0x7FFF_FFF8 (out of range), and rd_ctrl=110 with wr_ctrl=100 together -> each gives one cycle state=11, no mem_req, dout unchanged.
- ld with mem_ack never asserted -> mem_req drops and state=11 after TIMEOUT busy cycles, then 00. A subsequent ld with ack in the same cycle -> state 01 for exactly 1 cycle, dout=mem_rdata.
